// File: rtl/mopa_sequencer_if.sv
// mopa_sequencer_if: EX request channel plus the tile register file
// read/write port of the MOPA sequencer.
// slave  = sequencer side, master = EX / tile register file side.
interface mopa_sequencer_if #(
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int RW = $clog2(N)
) ();
   // request channel from EX
   logic            req_valid;
   logic            req_ready;
   logic            req_acc;
   logic [1:0]      req_md;
   logic [N*DW-1:0] req_va;
   logic [N*DW-1:0] req_vb;
   // status towards the pipeline
   logic            busy;
   logic            done;
   logic            stall;
   // tile register file read port
   logic            tile_ren;
   logic [1:0]      tile_rreg;
   logic [RW-1:0]   tile_rrow;
   logic [N*DW-1:0] tile_rdata;
   // tile register file write port
   logic            tile_we;
   logic [1:0]      tile_wreg;
   logic [RW-1:0]   tile_wrow;
   logic [N*DW-1:0] tile_wdata;

   modport slave (
      input  req_valid, req_acc, req_md, req_va, req_vb, tile_rdata,
      output req_ready, busy, done, stall,
             tile_ren, tile_rreg, tile_rrow,
             tile_we, tile_wreg, tile_wrow, tile_wdata
   );

   modport master (
      output req_valid, req_acc, req_md, req_va, req_vb, tile_rdata,
      input  req_ready, busy, done, stall,
             tile_ren, tile_rreg, tile_rrow,
             tile_we, tile_wreg, tile_wrow, tile_wdata
   );
endinterface

// File: rtl/mopa_sequencer.sv
// mopa_sequencer: multi-cycle MOPA sequencer. Accepts one request, streams
// the destination tile row by row through a read -> compute/write pipeline
// and pulses done once the last row is written.
// Build option: MOPA_SAT_EN selects signed saturating accumulate; without
// it the per-lane sum wraps modulo 2^DW.
module mopa_sequencer #(
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int RW = $clog2(N)
) (
   input logic             clk,
   input logic             rst,
   mopa_sequencer_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

   logic [1:0]           state;
   logic [RW-1:0]        cnt;

   // latched request payload, stable for the whole operation
   logic                 acc_q;
   logic [1:0]           md_q;
   logic [N-1:0][DW-1:0] va_q;
   logic [N-1:0][DW-1:0] vb_q;

   // write stage: row and its A multiplier, one cycle behind the read
   logic                 wr_vld;
   logic [RW-1:0]        wr_row;
   logic [DW-1:0]        wr_a;

   logic                 accept;
   logic                 rd_en;
   logic [N-1:0][DW-1:0] rdata;
   logic [N-1:0][DW-1:0] lane_res;

   assign accept = (state == S_IDLE) && bus.req_valid;
   assign rd_en  = (state == S_RUN);
   assign rdata  = bus.tile_rdata;

   // status and handshake; stall drops in DONE so EX advances on that edge
   assign bus.req_ready = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.stall     = bus.req_valid & ~bus.done;

   // address/data outputs are forced to zero whenever their enable is low
   assign bus.tile_ren   = rd_en;
   assign bus.tile_rreg  = rd_en ? md_q : 2'd0;
   assign bus.tile_rrow  = rd_en ? cnt : '0;
   assign bus.tile_we    = wr_vld;
   assign bus.tile_wreg  = wr_vld ? md_q : 2'd0;
   assign bus.tile_wrow  = wr_vld ? wr_row : '0;
   assign bus.tile_wdata = wr_vld ? lane_res : '0;

   // FSM: IDLE -> RUN (N reads) -> DRAIN (last write) -> DONE -> IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  state <= S_RUN;
                  cnt   <= '0;
               end
            end
            S_RUN: begin
               // counter wraps to 0 after the last row; nothing depends on it
               cnt <= cnt + 1'b1;
               if (cnt == LAST_ROW) state <= S_DRAIN;
            end
            S_DRAIN: state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // capture the request payload on acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= 1'b0;
         md_q  <= 2'd0;
         va_q  <= '0;
         vb_q  <= '0;
      end else if (accept) begin
         acc_q <= bus.req_acc;
         md_q  <= bus.req_md;
         va_q  <= bus.req_va;
         vb_q  <= bus.req_vb;
      end
   end

   // write-stage pipeline register; cleared on reset so an aborted
   // operation never issues a trailing write
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_vld <= 1'b0;
         wr_row <= '0;
         wr_a   <= '0;
      end else begin
         wr_vld <= rd_en;
         wr_row <= cnt;
         wr_a   <= va_q[cnt];
      end
   end

   // per-lane C[row][j] = (acc ? C : 0) + A[row]*B[j]
   for (genvar j = 0; j < N; j++) begin : g_lane
      logic [DW-1:0] prod;
      logic [DW-1:0] addend;

      // low DW bits of the product only
      assign prod   = wr_a * vb_q[j];
      assign addend = acc_q ? rdata[j] : '0;

`ifdef MOPA_SAT_EN
      logic [DW:0] sum_x;
      logic        ovf;

      // one guard bit: overflow when it disagrees with the result sign
      assign sum_x = {addend[DW-1], addend} + {prod[DW-1], prod};
      assign ovf   = sum_x[DW] ^ sum_x[DW-1];
      assign lane_res[j] = ovf ? {sum_x[DW], {(DW-1){~sum_x[DW]}}}
                               : sum_x[DW-1:0];
`else
      assign lane_res[j] = addend + prod;
`endif
   end

endmodule

// File: tb/tb_mopa_sequencer.sv
// tb_mopa_sequencer: randomized + directed bench for mopa_sequencer.
// Holds a 1R1W tile register file model, a whole-tile reference of the
// MOPA result and a per-cycle timeline of the expected handshake.
module tb_mopa_sequencer;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int RW = $clog2(N);

   typedef logic [N*DW-1:0] vec_t;

   logic clk;
   logic rst;

   mopa_sequencer_if #(.N(N), .DW(DW), .RW(RW)) ifc ();

   mopa_sequencer #(.N(N), .DW(DW), .RW(RW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // tile register file model: 4 tiles x N rows, flat index {reg,row}
   vec_t          mem   [4*N];
   vec_t          exp_t [4*N];
   logic          pl_we;
   logic [RW+1:0] pl_idx;
   vec_t          pl_data;

   // 1R1W storage without bypass; preload port used only while idle
   always @(posedge clk) begin
      if (ifc.tile_ren) ifc.tile_rdata <= mem[{ifc.tile_rreg, ifc.tile_rrow}];
      if (ifc.tile_we) mem[{ifc.tile_wreg, ifc.tile_wrow}] <= ifc.tile_wdata;
      else if (pl_we) mem[pl_idx] <= pl_data;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input vec_t got, input vec_t want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   // one element of the reference: plain integer arithmetic on 64 bits
   function automatic logic [DW-1:0] ref_elem(input logic [DW-1:0] c, a, b,
                                              input bit acc);
      logic [DW-1:0] p;
      longint        s;
      p = a * b;
      s = longint'($signed(acc ? c : 32'd0)) + longint'($signed(p));
`ifdef MOPA_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      return s[DW-1:0];
   endfunction

   task automatic ref_op(input bit acc, input logic [1:0] md,
                         input vec_t va, input vec_t vb);
      vec_t row;
      for (int i = 0; i < N; i++) begin
         row = exp_t[int'(md)*N + i];
         for (int j = 0; j < N; j++)
            row[j*DW +: DW] = ref_elem(row[j*DW +: DW], va[i*DW +: DW],
                                       vb[j*DW +: DW], acc);
         exp_t[int'(md)*N + i] = row;
      end
   endtask

   task automatic preload(input int idx, input vec_t d);
      pl_we   = 1'b1;
      pl_idx  = idx[RW+1:0];
      pl_data = d;
      exp_t[idx] = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic cmp_tile(input string tag);
      for (int k = 0; k < 4*N; k++)
         chk($sformatf("%s_row%0d", tag, k), mem[k], exp_t[k]);
   endtask

   // expected handshake/port activity in cycle c of an operation
   task automatic chk_cycle(input string tag, input int c,
                            input logic [1:0] md, input bit vld);
      bit e_ren, e_we;
      e_ren = (c >= 1) && (c <= N);
      e_we  = (c >= 2) && (c <= N + 1);
      chk($sformatf("%s_c%0d_ren", tag, c), ifc.tile_ren, e_ren);
      chk($sformatf("%s_c%0d_we", tag, c), ifc.tile_we, e_we);
      chk($sformatf("%s_c%0d_done", tag, c), ifc.done, c == N + 2);
      chk($sformatf("%s_c%0d_ready", tag, c), ifc.req_ready, (c == 0) || (c == N + 3));
      chk($sformatf("%s_c%0d_busy", tag, c), ifc.busy, (c >= 1) && (c <= N + 2));
      chk($sformatf("%s_c%0d_stall", tag, c), ifc.stall, vld && (c != N + 2));
      if (e_ren) begin
         chk($sformatf("%s_c%0d_rrow", tag, c), ifc.tile_rrow, vec_t'(c - 1));
         chk($sformatf("%s_c%0d_rreg", tag, c), ifc.tile_rreg, md);
      end
      if (e_we) begin
         chk($sformatf("%s_c%0d_wrow", tag, c), ifc.tile_wrow, vec_t'(c - 2));
         chk($sformatf("%s_c%0d_wreg", tag, c), ifc.tile_wreg, md);
      end
   endtask

   task automatic drive_req(input bit acc, input logic [1:0] md,
                            input vec_t va, input vec_t vb);
      ifc.req_acc = acc;
      ifc.req_md  = md;
      ifc.req_va  = va;
      ifc.req_vb  = vb;
   endtask

   // one complete operation, entered and left on a falling edge while idle
   task automatic single_op(input string tag, input bit acc, input logic [1:0] md,
                            input vec_t va, input vec_t vb);
      ref_op(acc, md, va, vb);
      drive_req(acc, md, va, vb);
      ifc.req_valid = 1'b1;
      for (int c = 0; c <= N + 3; c++) begin
         if (c == 1) ifc.req_valid = 1'b0;
         #1;
         chk_cycle(tag, c, md, c == 0);
         @(negedge clk);
      end
      cmp_tile(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t     va, vb, va2, vb2, old2, old3;
      logic [1:0] md;
      bit       acc, seen;

      rst = 1'b1;
      pl_we = 1'b0;
      pl_idx = '0;
      pl_data = '0;
      ifc.req_valid = 1'b0;
      drive_req(1'b0, 2'd0, '0, '0);

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", ifc.req_ready, 1);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_done", ifc.done, 0);
      chk("rst_stall", ifc.stall, 0);
      chk("rst_ren", ifc.tile_ren, 0);
      chk("rst_we", ifc.tile_we, 0);
      chk("rst_rreg", ifc.tile_rreg, 0);
      chk("rst_rrow", ifc.tile_rrow, 0);
      chk("rst_wreg", ifc.tile_wreg, 0);
      chk("rst_wrow", ifc.tile_wrow, 0);
      chk("rst_wdata", ifc.tile_wdata, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4*N; k++) preload(k, '0);

      // overwrite, tile 2
      single_op("ovw", 1'b0, 2'd2, mk(1, 2, 3, 4), mk(5, 6, 7, 8));
      chk("ovw_r0", mem[2*N+0], mk(5, 6, 7, 8));
      chk("ovw_r1", mem[2*N+1], mk(10, 12, 14, 16));
      chk("ovw_r2", mem[2*N+2], mk(15, 18, 21, 24));
      chk("ovw_r3", mem[2*N+3], mk(20, 24, 28, 32));

      // accumulate into tile 1 preloaded with 10
      for (int r = 0; r < N; r++) preload(N + r, mk(10, 10, 10, 10));
      single_op("acc", 1'b1, 2'd1, mk(1, 2, 3, 4), mk(5, 6, 7, 8));
      chk("acc_r1", mem[N+1], mk(20, 22, 24, 26));
      chk("acc_r3", mem[N+3], mk(30, 34, 38, 42));

      // signed overflow boundary: wrap or clamp
      preload(0, mk(32'h7FFF_FFFF, 0, 0, 0));
      single_op("ovf", 1'b1, 2'd0, mk(1, 0, 0, 0), mk(1, 0, 0, 0));
`ifdef MOPA_SAT_EN
      chk("ovf_e00", mem[0][DW-1:0], 32'h7FFF_FFFF);
`else
      chk("ovf_e00", mem[0][DW-1:0], 32'h8000_0000);
`endif
      // product keeps only its low DW bits
      single_op("lowp", 1'b0, 2'd0, mk(32'h10000, 0, 0, 0), mk(32'h10000, 0, 0, 0));
      chk("lowp_e00", mem[0][DW-1:0], 0);

      // randomized operations
      for (int t = 0; t < 10; t++) begin
         md  = 2'($urandom_range(0, 3));
         acc = 1'($urandom_range(0, 1));
         for (int r = 0; r < N; r++)
            preload(int'(md)*N + r, {$urandom, $urandom, $urandom, $urandom});
         va = {$urandom, $urandom, $urandom, $urandom};
         vb = {$urandom, $urandom, $urandom, $urandom};
         if (t[0]) va = va & {N{32'h0000_FFFF}};
         single_op($sformatf("rnd%0d", t), acc, md, va, vb);
      end

      // back-to-back: req_valid held, payload changes after first accept
      va  = {$urandom, $urandom, $urandom, $urandom};
      vb  = {$urandom, $urandom, $urandom, $urandom};
      va2 = {$urandom, $urandom, $urandom, $urandom};
      vb2 = {$urandom, $urandom, $urandom, $urandom};
      ref_op(1'b1, 2'd1, va, vb);
      ref_op(1'b1, 2'd1, va2, vb2);
      drive_req(1'b1, 2'd1, va, vb);
      ifc.req_valid = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         if (c == 1) drive_req(1'b1, 2'd1, va2, vb2);
         #1;
         chk($sformatf("b2b_c%0d_ready", c), ifc.req_ready, (c == 0) || (c == 7));
         chk($sformatf("b2b_c%0d_stall", c), ifc.stall, c != 6);
         @(negedge clk);
      end
      ifc.req_valid = 1'b0;
      #1;
      chk("b2b_second_ren", ifc.tile_ren, 1);
      chk("b2b_second_rrow", ifc.tile_rrow, 0);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         #1;
         seen = ifc.done;
      end
      chk("b2b_done_seen", seen, 1);
      @(negedge clk);
      @(negedge clk);
      cmp_tile("b2b");

      // reset during an overwrite: sampled on the edge ending cycle 3
      for (int r = 0; r < N; r++)
         preload(3*N + r, {$urandom, $urandom, $urandom, $urandom});
      old2 = exp_t[3*N+2];
      old3 = exp_t[3*N+3];
      va = {$urandom, $urandom, $urandom, $urandom};
      vb = {$urandom, $urandom, $urandom, $urandom};
      ref_op(1'b0, 2'd3, va, vb);
      exp_t[3*N+2] = old2;
      exp_t[3*N+3] = old3;
      drive_req(1'b0, 2'd3, va, vb);
      ifc.req_valid = 1'b1;
      for (int c = 0; c <= 3; c++) begin
         if (c == 1) ifc.req_valid = 1'b0;
         #1;
         if (c == 3) begin
            chk("mid_c3_we", ifc.tile_we, 1);
            chk("mid_c3_wrow", ifc.tile_wrow, 1);
            rst = 1'b1;
         end
         @(negedge clk);
      end
      #1;
      chk("mid_c4_we", ifc.tile_we, 0);
      chk("mid_c4_done", ifc.done, 0);
      chk("mid_c4_ready", ifc.req_ready, 1);
      chk("mid_c4_busy", ifc.busy, 0);
      chk("mid_c4_ren", ifc.tile_ren, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (ifc.done || ifc.tile_we) seen = 1'b1;
         @(negedge clk);
      end
      chk("mid_no_done_we", seen, 0);
      cmp_tile("mid");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
